// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

   localparam int ADDR_W_DEFAULT = 9;
   localparam int DATA_W_DEFAULT = 32;
   localparam int MAX_WORDS      = 2**ADDR_W_DEFAULT;
   localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;
   localparam int LEN_W          = 16;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      PAYLOAD,
      WRITE,
      CSUM,
      RUN,
      ERR
   } loaderState_t;

   // A program must hold at least one word and fit the instruction RAM.
   function automatic logic lenOk(input logic [LEN_W-1:0] len, input int maxWords);
      return (len != '0) && (int'(len) <= maxWords);
   endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles big-endian stream bytes into instruction words; clear discards a partial word.
module byte_packer
   import prog_loader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              shiftEn,
   input  logic [7:0]        inByte,
   output logic [DATA_W-1:0] wordNext,
   output logic              wordDone
);

   localparam int BPW   = DATA_W / 8;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

   // Only the low bytes are kept; the oldest byte leaves through wordNext.
   logic [DATA_W-9:0] shiftReg;
   logic [CNT_W-1:0]  byteCnt;

   assign wordNext = {shiftReg, inByte};
   assign wordDone = shiftEn && (byteCnt == CNT_W'(BPW - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shiftReg <= '0;
         byteCnt  <= '0;
      end else if (clear) begin
         shiftReg <= '0;
         byteCnt  <= '0;
      end else if (shiftEn) begin
         shiftReg <= wordNext[DATA_W-9:0];
         byteCnt  <= wordDone ? '0 : byteCnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed big-endian word stream into instruction RAM, then raises working.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] addr,
   output logic              wr,
   output logic [DATA_W-1:0] wdata,
   output logic              working,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int MAX_LOAD = 2**ADDR_W;

   loaderState_t     state;
   logic [LEN_W-1:0] lenReg;
   logic [LEN_W-1:0] lenNext;
   logic             accept;
   logic             lastWord;
   logic             wordDone;
   logic [DATA_W-1:0] wordNext;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   // NOTE: in_ready is combinational so a start pulse can refuse the byte presented with it.
   assign in_ready = !start && (state == LEN_HI || state == LEN_LO ||
                                state == PAYLOAD || state == CSUM);
   assign accept   = in_valid && in_ready;
   assign lenNext  = {lenReg[LEN_W-1:8], in_data};
   assign lastWord = (LEN_W'(words_loaded) + LEN_W'(1)) == lenReg;

   byte_packer #(.DATA_W(DATA_W)) u_packer (
      .clock    (clock),
      .reset    (reset),
      .clear    (start),
      .shiftEn  (accept && state == PAYLOAD),
      .inByte   (in_data),
      .wordNext (wordNext),
      .wordDone (wordDone)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         lenReg       <= '0;
         addr         <= '0;
         wr           <= 1'b0;
         wdata        <= '0;
         working      <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else if (start) begin
         state        <= LEN_HI;
         wr           <= 1'b0;
         working      <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         case (state)
            LEN_HI: begin
               if (accept) begin
                  lenReg[LEN_W-1:8] <= in_data;
                  state             <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (accept) begin
                  lenReg <= lenNext;
                  if (lenOk(lenNext, MAX_LOAD)) begin
                     state <= PAYLOAD;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
            PAYLOAD: begin
               if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                  csum <= csum ^ in_data;
`endif
                  if (wordDone) begin
                     state <= WRITE;
                     wr    <= 1'b1;
                     addr  <= words_loaded[ADDR_W-1:0];
                     wdata <= wordNext;
                  end
               end
            end
            WRITE: begin
               wr           <= 1'b0;
               words_loaded <= words_loaded + (ADDR_W+1)'(1);
               if (lastWord) begin
`ifdef LOADER_CHECKSUM_EN
                  state   <= CSUM;
`else
                  state   <= RUN;
                  working <= 1'b1;
`endif
               end else begin
                  state <= PAYLOAD;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  if (in_data == csum) begin
                     state   <= RUN;
                     working <= 1'b1;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            IDLE, RUN, ERR: begin
               // Only start or reset leaves these states.
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader with a word-level scoreboard model.
module tb_prog_loader;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int MAXW   = 512;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic [ADDR_W-1:0] addr;
   logic              wr;
   logic [DATA_W-1:0] wdata;
   logic              working;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wrExp_t;

   int          nCmp = 0;
   int          nErr = 0;
   int          modelCount = 0;
   bit          gapMode = 1'b0;
   logic [31:0] wordBuf [MAXW];
   wrExp_t      expQ [$];

   prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .addr         (addr),
      .wr           (wr),
      .wdata        (wdata),
      .working      (working),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every wr pulse must match the next expected word, and
   // words_loaded must equal the pulses seen since the last start/reset.
   initial begin
      wrExp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (reset) begin
            modelCount = 0;
         end else begin
            check("words_loaded", 64'(words_loaded), 64'(modelCount));
            if (wr) begin
               if (expQ.size() == 0) begin
                  check("unexpected_wr", 1, 0);
               end else begin
                  e = expQ.pop_front();
                  check("wr_addr", 64'(addr), 64'(e.addr));
                  check("wr_data", 64'(wdata), 64'(e.data));
               end
               modelCount++;
            end
            if (start) modelCount = 0;
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic sendByte(input logic [7:0] b);
      int budget;
      bit done;
      budget = 100;
      done   = 1'b0;
      if (gapMode) begin
         while ($urandom_range(1, 0) == 1) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clock);
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!done) begin
         #1;
         if (in_ready) done = 1'b1;
         @(negedge clock);
         if (!done) begin
            budget--;
            if (budget == 0) begin
               check("in_ready_timeout", 0, 1);
               done = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic pulseStart();
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      #1;
      check("in_ready_during_start", 64'(in_ready), 0);
      @(negedge clock);
      start    = 1'b0;
      in_valid = 1'b0;
      check("start_clears_error", 64'(error), 0);
      check("start_clears_working", 64'(working), 0);
   endtask

   // Sends a header for len words followed by nPay payload bytes from wordBuf.
   task automatic sendLoad(input int len, input int nPay, input bit badCsum);
      logic [15:0] l16;
      logic [7:0]  x;
      int          t;
      l16 = 16'(len);
      x   = 8'h00;
      check("queue_empty_before_load", 64'(expQ.size()), 0);
      pulseStart();
      sendByte(l16[15:8]);
      sendByte(l16[7:0]);
      if (len == 0 || len > MAXW) begin
         repeat (3) @(negedge clock);
         check("bad_len_error", 64'(error), 1);
         check("bad_len_working", 64'(working), 0);
         check("bad_len_in_ready", 64'(in_ready), 0);
         return;
      end
      for (int i = 0; i < nPay; i++) begin
         logic [31:0] w;
         logic [7:0]  b;
         w = wordBuf[i / 4];
         b = w[31 - 8 * (i % 4) -: 8];
         x = x ^ b;
         sendByte(b);
         if (i % 4 == 3) expQ.push_back('{i / 4, w});
      end
      if (nPay < 4 * len) return;
`ifdef LOADER_CHECKSUM_EN
      sendByte(badCsum ? (x ^ 8'h01) : x);
`endif
      t = 0;
      while (!working && !error && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (badCsum) begin
         check("csum_bad_error", 64'(error), 1);
         check("csum_bad_working", 64'(working), 0);
      end else begin
         check("run_working", 64'(working), 1);
         check("run_error", 64'(error), 0);
      end
      check("done_words_loaded", 64'(words_loaded), 64'(len));
      check("done_in_ready", 64'(in_ready), 0);
      check("done_queue_empty", 64'(expQ.size()), 0);
   endtask

   task automatic fillRandom(input int n);
      for (int i = 0; i < n; i++) wordBuf[i] = $urandom;
   endtask

   initial begin
      int len;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_addr", 64'(addr), 0);
      check("rst_wr", 64'(wr), 0);
      check("rst_wdata", 64'(wdata), 0);
      check("rst_working", 64'(working), 0);
      check("rst_error", 64'(error), 0);
      check("rst_words_loaded", 64'(words_loaded), 0);
      check("rst_in_ready", 64'(in_ready), 0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_in_ready", 64'(in_ready), 0);

      // Fixed 12-word program.
      for (int i = 0; i < 8; i++) wordBuf[i] = 32'h10F00080 + 32'(i) * 32'h00010001;
      wordBuf[8]  = 32'h20010000;
      wordBuf[9]  = 32'h21230000;
      wordBuf[10] = 32'h22450000;
      wordBuf[11] = 32'h23670000;
      sendLoad(12, 48, 1'b0);
      check("prog12_last_addr", 64'(addr), 11);
      check("prog12_last_wdata", 64'(wdata), 64'h23670000);
      check("prog12_words", 64'(words_loaded), 12);

      // Illegal lengths, then a start clearing the error.
      sendLoad(0, 0, 1'b0);
      pulseStart();
      repeat (2) @(negedge clock);
      sendLoad(513, 0, 1'b0);

      // Full-size program.
      fillRandom(MAXW);
      sendLoad(512, 2048, 1'b0);
      check("full_last_addr", 64'(addr), 511);
      check("full_words", 64'(words_loaded), 512);

      // Gappy stream.
      fillRandom(3);
      gapMode = 1'b1;
      sendLoad(3, 12, 1'b0);
      gapMode = 1'b0;

      // Abort after 6 payload bytes, then a single-word load.
      fillRandom(2);
      sendLoad(2, 6, 1'b0);
      wordBuf[0] = 32'h10F30083;
      sendLoad(1, 4, 1'b0);
      check("abort_addr", 64'(addr), 0);
      check("abort_wdata", 64'(wdata), 64'h10F30083);
      check("abort_words", 64'(words_loaded), 1);

      // Random loads.
      repeat (6) begin
         len = $urandom_range(20, 1);
         fillRandom(len);
         gapMode = 1'($urandom);
         sendLoad(len, 4 * len, 1'b0);
      end
      gapMode = 1'b0;

      // Reset in the middle of a load.
      fillRandom(3);
      sendLoad(3, 6, 1'b0);
      reset = 1'b1;
      #1;
      check("midrst_wr", 64'(wr), 0);
      check("midrst_in_ready", 64'(in_ready), 0);
      check("midrst_words", 64'(words_loaded), 0);
      check("midrst_wdata", 64'(wdata), 0);
      @(negedge clock);
      reset = 1'b0;
      expQ.delete();
      @(negedge clock);
      check("midrst_idle_in_ready", 64'(in_ready), 0);

`ifdef LOADER_CHECKSUM_EN
      wordBuf[0] = 32'h10F00080;
      sendLoad(1, 4, 1'b0);
      sendLoad(1, 4, 1'b1);
`endif

      repeat (5) @(negedge clock);
      check("final_queue_empty", 64'(expQ.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
